// File: rtl/ahb_slave_mem.sv
// AHB-Lite slave memory: DEPTH x 32-bit words with optional wait states.
// All transfers are treated as 32-bit; hsize/hburst are ignored.
// Optional feature macro: AHB_SLAVE_MEM_ERR_EN. When it is defined, an address
// above the memory range gets a two-cycle ERROR response. When it is not
// defined, the upper address bits are ignored and the address wraps.
module ahb_slave_mem #(
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic [1:0]  htrans,
  input  logic        hready,
  input  logic [31:0] hwdata,
  output logic        hreadyout,
  output logic        hresp,
  output logic [31:0] hrdata
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  state_t        state, state_nxt;
  logic [2:0]    cnt, cnt_nxt;
  logic [AW-1:0] idx_q;
  logic          wr_q;
  logic [31:0]   mem [DEPTH];
  logic          accept;
  logic          oor;
  logic          unused_ok;

  // A new address phase is taken only when this slave is able to start
  // one, that is in IDLE or in the last (ready) cycle of a data phase.
  assign accept = hsel & hready & htrans[1] &
                  ((state == S_IDLE) || (state == S_DATA));

`ifdef AHB_SLAVE_MEM_ERR_EN
  assign oor   = (haddr[31:AW+2] != '0);
  assign hresp = (state == S_ERR1) || (state == S_ERR2);
`else
  assign oor   = 1'b0;
  assign hresp = 1'b0;
`endif

  assign unused_ok = ^{hsize, hburst, haddr[1:0], haddr[31:AW+2]};

  // The slave stalls only while counting wait states and in the first error cycle.
  assign hreadyout = !((state == S_WAIT) || (state == S_ERR1));
  assign hrdata    = (state == S_DATA && !wr_q) ? mem[idx_q] : '0;

  // State and wait counter register
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic: IDLE and DATA both re-enter on an accept, with no gap
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE, S_DATA: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
        if (accept) begin
          if (oor) begin
            state_nxt = S_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_nxt = S_WAIT;
            cnt_nxt   = 3'(WAIT_STATES);
          end else begin
            state_nxt = S_DATA;
          end
        end
      end
      S_WAIT: begin
        cnt_nxt = cnt - 3'd1;
        if (cnt <= 3'd1) begin
          state_nxt = S_DATA;
          cnt_nxt   = '0;
        end
      end
      S_ERR1:  state_nxt = S_ERR2;
      S_ERR2:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Capture the address-phase controls of each accepted transfer
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      idx_q <= '0;
      wr_q  <= 1'b0;
    end else if (accept) begin
      idx_q <= haddr[AW+1:2];
      wr_q  <= hwrite;
    end
  end

  // Storage array: cleared by reset, written at the end of a write data phase
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (state == S_DATA && wr_q) begin
      mem[idx_q] <= hwdata;
    end
  end

endmodule
